// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: single pipeline register stage with valid/ready handshake,
// flush (bubble insert) and bubble-zeroed control payload.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer and a
// registered o_ready. Without the macro, o_ready is combinational.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 95,
   parameter int unsigned CTRL_W = 13
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              accept;
   logic              emit;

`ifdef PIPE_STAGE_REG_SKID_EN
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              ready_q, ready_d;

   assign o_ready = ready_q;
`else
   assign o_ready = !o_valid || i_ready;
`endif

   assign o_valid = (state_q != EMPTY);
   assign o_data  = data_q;
   assign o_ctrl  = ctrl_q;
   assign accept  = i_valid && o_ready;
   assign emit    = o_valid && i_ready;

   // Occupancy decode from the current state.
   always_comb begin
      o_occ = 2'd0;
      case (state_q)
         EMPTY:   o_occ = 2'd0;
         FULL:    o_occ = 2'd1;
         SKID:    o_occ = 2'd2;
         default: o_occ = 2'd0;
      endcase
   end

   // Next-state and payload steering; control is zeroed whenever the stage goes empty.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
`endif
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
               data_d  = i_data;
               ctrl_d  = i_ctrl;
            end
         end
         FULL: begin
            if (accept && emit) begin
               data_d = i_data;
               ctrl_d = i_ctrl;
            end else if (emit) begin
               state_d = EMPTY;
               ctrl_d  = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
            end else if (accept) begin
               state_d     = SKID;
               skid_data_d = i_data;
               skid_ctrl_d = i_ctrl;
`endif
            end
         end
`ifdef PIPE_STAGE_REG_SKID_EN
         SKID: begin
            if (emit) begin
               state_d     = FULL;
               data_d      = skid_data_q;
               ctrl_d      = skid_ctrl_q;
               skid_ctrl_d = '0;
            end
         end
`endif
         default: begin
            state_d = EMPTY;
            ctrl_d  = '0;
         end
      endcase
      // Flush overrides any handshake this cycle; o_data keeps its last value.
      if (i_flush) begin
         state_d = EMPTY;
         data_d  = data_q;
         ctrl_d  = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_data_d = skid_data_q;
         skid_ctrl_d = '0;
`endif
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      ready_d = (state_d != SKID);
`endif
   end

   // State and payload registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         ctrl_q  <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         ready_q     <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         ready_q     <= ready_d;
`endif
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 95, width of datapath payload (imm, busA, busB, Rw).
REQ-002 SHALL have parameter CTRL_W, default 13, width of control payload (EX, M, WB fields).
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  upstream offers a beat.
REQ-006 SHALL have port o_ready  output  1  stage can accept a beat this cycle.
REQ-007 SHALL have port i_data  input  DATA_W  upstream datapath payload.
REQ-008 SHALL have port i_ctrl  input  CTRL_W  upstream control payload.
REQ-009 SHALL have port i_flush  input  1  discard all held and incoming beats (bubble insert).
REQ-010 SHALL have port o_valid  output  1  stage presents a beat downstream.
REQ-011 SHALL have port i_ready  input  1  downstream accepts the presented beat.
REQ-012 SHALL have port o_data  output  DATA_W  presented datapath payload.
REQ-013 SHALL have port o_ctrl  output  CTRL_W  presented control payload.
REQ-014 SHALL have port o_occ  output  2  occupancy, 0..2 beats held.

Function
REQ-015 Input handshake SHALL occur when i_valid && o_ready; output handshake SHALL occur when o_valid && i_ready.
REQ-016 Latency SHALL be exactly 1 cycle: a beat accepted into an empty stage appears on o_valid/o_data/o_ctrl the next cycle.
REQ-017 Beats SHALL leave in acceptance order with no loss or duplication; o_data/o_ctrl SHALL remain stable while o_valid && !i_ready.
REQ-018 o_ctrl SHALL be all-zero in every cycle o_valid=0 (bubble carries no EX/M/WB side effects); o_data is don't-care but SHALL hold its last value.
REQ-019 States: EMPTY (occ 0), FULL (occ 1), SKID (occ 2, only with macro); o_occ SHALL equal the state's occupancy.
REQ-020 EMPTY: accept -> FULL; no accept -> EMPTY.
REQ-021 FULL: accept && emit -> FULL (new beat presented); emit only -> EMPTY; accept only -> SKID (macro on) or not possible (macro off); neither -> FULL.
REQ-022 SKID: o_ready=0; emit -> FULL with skid beat moved to output register; no emit -> SKID.
REQ-023 i_flush=1 SHALL force next state EMPTY, o_valid=0, o_ctrl=0, o_occ=0, discarding any beat handshaked in the same cycle on either side.
REQ-024 Priority SHALL be reset > flush > handshakes.

Reset
REQ-025 While i_rst_n=0 at a rising edge: o_valid=0, o_ctrl=0, o_data=0, o_occ=0, state EMPTY, skid entry cleared.
REQ-026 o_ready SHALL be 1 in the first cycle after reset release; reset mid-transfer SHALL discard all held beats.

Configuration
REQ-027 Macro PIPE_STAGE_REG_SKID_EN defined: one-entry skid buffer present; o_ready SHALL be a register output equal to (state != SKID), with no combinational path from i_ready.
REQ-028 Macro undefined: no skid entry; o_ready SHALL equal (!o_valid || i_ready) combinationally; SKID state and occ=2 SHALL never occur.

Verification
REQ-029 Reset, then i_valid=1, i_data=0x5, i_ctrl=0x1FFF, i_ready=1 -> next cycle o_valid=1, o_data=0x5, o_ctrl=0x1FFF, o_occ=1.
REQ-030 Stream beats 1..8 back-to-back with i_ready=1 -> output 1..8 on consecutive cycles, o_ready constantly 1.
REQ-031 Macro on: output holding beat A, i_ready=0, send B -> o_occ=2, o_ready=0, o_data=A stable; raise i_ready -> A then B, o_occ 2->1->0.
REQ-032 Macro off: same stimulus -> B not accepted (o_ready=0) until A emitted; o_occ never exceeds 1.
REQ-033 occ=2, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_occ=0; no flushed beat ever appears.
REQ-034 i_rst_n=0 asserted with occ=1 and i_valid=1 -> next cycle all outputs 0, o_occ=0; after release o_ready=1.
